booth_r16_digit_seq: RTL and testbench

Sequential radix-16 Booth recoder that sits directly upstream of the partial-product generator. It accepts a WIDTH-bit multiplier operand over a valid/ready handshake, then emits one Booth digit per handshake cycle. Each digit is a `mul_pkg::booth_sel_t` magnitude select (PP_0..PP_8A) plus a negate flag, running from least to most significant, with an index and a last marker. It replaces the parallel encoder array in iterative, area-reduced multiplier configurations.

---
 rtl/booth_r16_digit_seq.sv | 135 +++++++++++++
 tb/tb_booth_r16_digit_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r16_digit_seq.sv
// Sequential radix-16 Booth recoder: accepts one multiplier operand and
// streams its signed digits (magnitude select + negate), LSD first.
package mul_pkg;
  typedef enum logic [3:0] {
    PP_0  = 4'd0,
    PP_A  = 4'd1,
    PP_2A = 4'd2,
    PP_3A = 4'd3,
    PP_4A = 4'd4,
    PP_5A = 4'd5,
    PP_6A = 4'd6,
    PP_7A = 4'd7,
    PP_8A = 4'd8
  } booth_sel_t;
endpackage

module booth_r16_digit_seq #(
  parameter int WIDTH     = 52,
  parameter bit SIGNED_OP = 1'b0,
  localparam int NDIG     = SIGNED_OP ? (WIDTH + 3) / 4 : WIDTH / 4 + 1,
  localparam int IW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    in_b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output mul_pkg::booth_sel_t out_sel_o,
  output logic                out_neg_o,
  output logic [IW-1:0]       out_idx_o,
  output logic                out_last_o
);
  localparam int EW  = NDIG * 4;
  localparam int SRW = EW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_next;
  logic [SRW-1:0]  sr, sr_next;
  logic [IW-1:0]   idx, idx_next;
  logic [EW-1:0]   ext_b;
  logic [3:0]      fill;
  logic [3:0]      pos_sum;
  logic [3:0]      mag;
  logic            neg;
  logic            is_last;
  logic            accept;
  logic            digit_hs;

  if (SIGNED_OP) begin : g_sext
    assign ext_b = EW'($signed(in_b_i));
    assign fill  = {4{sr[SRW-1]}};
  end else begin : g_zext
    assign ext_b = EW'(in_b_i);
    assign fill  = 4'b0000;
  end

  // Non-negative part 4*b2 + 2*b1 + b0 + b-1 (0..8); b3 contributes -8.
  assign pos_sum = {1'b0, sr[3:1]} + {3'b000, sr[0]};

  always_comb begin
    mag = pos_sum;
    neg = 1'b0;
    if (sr[4]) begin
      mag = 4'd8 - pos_sum;
      neg = (pos_sum != 4'd8);
    end
  end

  assign is_last  = (idx == IW'(NDIG - 1));
  assign accept   = in_valid_i && in_ready_o;
  assign digit_hs = out_valid_o && out_ready_i;

  always_comb begin
    out_valid_o = 1'b0;
    out_sel_o   = mul_pkg::PP_0;
    out_neg_o   = 1'b0;
    out_idx_o   = '0;
    out_last_o  = 1'b0;
    if (state == SCAN) begin
      out_valid_o = 1'b1;
      out_sel_o   = mul_pkg::booth_sel_t'(mag);
      out_neg_o   = neg;
      out_idx_o   = idx;
      out_last_o  = is_last;
    end
  end

  assign in_ready_o = (state == IDLE) || (out_valid_o && out_ready_i && out_last_o);

  always_comb begin
    state_next = state;
    sr_next    = sr;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (accept) begin
          sr_next    = {ext_b, 1'b0};
          idx_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (digit_hs) begin
          if (!is_last) begin
            sr_next  = {fill, sr[SRW-1:4]};
            idx_next = idx + IW'(1);
          end else if (accept) begin
            // Next operand loads on the last-digit edge so there is no bubble.
            sr_next  = {ext_b, 1'b0};
            idx_next = '0;
          end else begin
            idx_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      idx   <= idx_next;
    end
  end
endmodule

// File: tb/tb_booth_r16_digit_seq.sv
// Bench for booth_r16_digit_seq: unsigned and signed instances share stimulus;
// each is checked every cycle against an arithmetic digit model.
module tb_booth_r16_digit_seq;
  localparam int W = 52;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_b;

  logic         in_ready  [2];
  logic         out_valid [2];
  logic [3:0]   out_sel   [2];
  logic         out_neg   [2];
  logic [3:0]   out_idx   [2];
  logic         out_last  [2];

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_cnt [2] = '{0, 0};
  int ops_done[2] = '{0, 0};
  bit verbose = 1'b1;

  int     expq [2][$];
  longint xq   [2][$];
  longint accum[2] = '{0, 0};

  always #5 clk = ~clk;

  booth_r16_digit_seq #(.WIDTH(W), .SIGNED_OP(1'b0)) u_uns (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .in_b_i(in_b), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .out_sel_o(out_sel[0]), .out_neg_o(out_neg[0]), .out_idx_o(out_idx[0]),
    .out_last_o(out_last[0])
  );

  booth_r16_digit_seq #(.WIDTH(W), .SIGNED_OP(1'b1)) u_sgn (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .in_b_i(in_b), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .out_sel_o(out_sel[1]), .out_neg_o(out_neg[1]), .out_idx_o(out_idx[1]),
    .out_last_o(out_last[1])
  );

  function automatic int nd_of(int k);
    return (k == 0) ? 14 : 13;
  endfunction

  function automatic longint ext_of(logic [W-1:0] b, int k);
    longint x;
    if (k == 0) x = longint'({12'b0, b});
    else        x = longint'($signed(b));
    return x;
  endfunction

  // F_i = round-half-up(X / 16^i); digit_i = F_i - 16*F_{i+1} telescopes to X.
  function automatic longint fround(longint x, int i);
    longint one = 1;
    if (i == 0) return x;
    return (x + (one <<< (4 * i - 1))) >>> (4 * i);
  endfunction

  function automatic int model_digit(longint x, int i);
    return int'(fround(x, i) - 16 * fround(x, i + 1));
  endfunction

  function automatic void chk(string nm, int k, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %0d want %0d", nm, k, $time, act, exp);
    end
  endfunction

  task automatic monitor(int k);
    int     nd = nd_of(k);
    bit     ev, er, hs;
    int     v;
    int     ei;
    longint one = 1;
    longint x;
    if (rst) begin
      expq[k].delete();
      xq[k].delete();
      accum[k] = 0;
      chk("rst_valid", k, out_valid[k], 0);
      chk("rst_idx",   k, out_idx[k],   0);
      chk("rst_sel",   k, out_sel[k],   0);
      chk("rst_neg",   k, out_neg[k],   0);
      chk("rst_last",  k, out_last[k],  0);
      chk("rst_ready", k, in_ready[k],  1);
      return;
    end
    ev = (expq[k].size() != 0);
    chk("valid", k, out_valid[k], ev);
    v  = ev ? expq[k][0] : 0;
    ei = ev ? nd - expq[k].size() : 0;
    chk("sel",  k, out_sel[k],  (v < 0) ? -v : v);
    chk("neg",  k, out_neg[k],  v < 0);
    chk("idx",  k, out_idx[k],  ei);
    chk("last", k, out_last[k], ev && expq[k].size() == 1);
    er = !ev || (out_ready && expq[k].size() == 1);
    chk("in_ready", k, in_ready[k], er);
    hs = ev && out_ready;
    if (hs) begin
      accum[k] += longint'(v) * (one <<< (4 * ei));
      void'(expq[k].pop_front());
      if (expq[k].size() == 0) begin
        x = xq[k].pop_front();
        chk("recon", k, accum[k], x);
        if (verbose)
          $display("op[%0d] #%0d B=%0d recon=%0d", k, ops_done[k], x, accum[k]);
        accum[k] = 0;
        ops_done[k]++;
      end
    end
    if (in_valid && er) begin
      x = ext_of(in_b, k);
      xq[k].push_back(x);
      for (int i = 0; i < nd; i++) expq[k].push_back(model_digit(x, i));
      acc_cnt[k]++;
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  task automatic send(logic [W-1:0] b);
    int c = acc_cnt[0];
    int t = 0;
    in_valid = 1'b1;
    in_b     = b;
    while (acc_cnt[0] == c && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (acc_cnt[0] == c) chk("send_timeout", 0, 1, 0);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (expq[0].size() != 0 || expq[1].size() != 0) chk("idle_timeout", 0, 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(int target);
    int t = 0;
    while (out_idx[0] != 4'(target) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_idx", 0, out_idx[0], target);
  endtask

  initial begin
    logic [3:0]  h_sel;
    logic        h_neg;
    logic [63:0] r;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_b = '0;

    // Hand-computed digits pin the reference model.
    chk("model_F_d0", 0, model_digit(15, 0), -1);
    chk("model_F_d1", 0, model_digit(15, 1), 1);
    chk("model_8_d0", 0, model_digit(8, 0), -8);
    chk("model_m1_d1", 1, model_digit(-1, 1), 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(52'h0);
    wait_idle();
    send(52'hF);
    chk("lit_F_sel", 0, out_sel[0], 1);
    chk("lit_F_neg", 0, out_neg[0], 1);
    wait_idle();
    send(52'h8);
    chk("lit_8_sel", 0, out_sel[0], 8);
    chk("lit_8_neg", 0, out_neg[0], 1);
    wait_idle();
    send({W{1'b1}});
    chk("lit_m1_sel", 1, out_sel[1], 1);
    chk("lit_m1_neg", 1, out_neg[1], 1);
    wait_idle();

    // Back-pressure at digit 5: the held digit must not change.
    send(52'h123456789ABCD);
    wait_idx(5);
    h_sel = out_sel[0];
    h_neg = out_neg[0];
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sel", 0, out_sel[0], h_sel);
    chk("hold_neg", 0, out_neg[0], h_neg);
    chk("hold_idx", 0, out_idx[0], 5);
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back operands with in_valid held high.
    begin
      int c = acc_cnt[0];
      int t = 0;
      in_valid = 1'b1;
      in_b     = 52'hA5A5_5A5A_0F0F1;
      while (acc_cnt[0] == c && t < 50) begin @(posedge clk); t++; end
      #1 in_b = 52'h8_0000_0000_0007;
      c = acc_cnt[0]; t = 0;
      while (acc_cnt[0] == c && t < 50) begin @(posedge clk); t++; end
      chk("b2b_accept", 0, acc_cnt[0], c + 1);
      #1 in_valid = 1'b0;
    end
    wait_idle();

    // Asynchronous reset in the middle of an operand.
    send(52'hF_EDCB_A987_6543);
    wait_idx(7);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 0, out_valid[0], 0);
    chk("arst_idx",   0, out_idx[0],   0);
    chk("arst_valid", 1, out_valid[1], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(52'h7);
    chk("post_rst_idx", 0, out_idx[0], 0);
    wait_idle();

    // Random regression.
    verbose = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       in_b = '0;
        1:       in_b = {W{1'b1}};
        2:       in_b = {1'b1, {(W-1){1'b0}}};
        3:       in_b = {W/4{4'h8}};
        default: in_b = r[W-1:0];
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    $display("operands completed: unsigned %0d signed %0d", ops_done[0], ops_done[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
